// File: rtl/lab3_sr_pulse_driver.sv
// lab3_sr_pulse_driver
//   Command stage in front of a gate-level SR latch. Two raw push buttons are
//   synchronised (2 flops) and debounced, and each debounced press becomes a
//   single fixed-width S or R pulse followed by a recovery gap. S and R are
//   never high together. exp_q tracks the Q the latch should hold.
//
//   Optional feature macro: SR_CHECK_EN
//     defined   : q_fb is compared with exp_q in the last GAP cycle of every
//                 command; a mismatch sets the sticky err flag until rst.
//     undefined : q_fb is ignored and err is constant 0.
//
// Ports
//   clk      in   single clock, rising edge
//   rst      in   synchronous active-high reset
//   set_btn  in   raw set button (asynchronous, bouncy)
//   clr_btn  in   raw clear button (asynchronous, bouncy)
//   q_fb     in   latch Q feedback (SR_CHECK_EN only)
//   S, R     out  latch drives, decoded straight from the state register
//   busy     out  high in SET_P, CLR_P and GAP
//   exp_q    out  expected latch Q after the last completed pulse
//   conflict out  one-cycle flag: both presses seen in the same IDLE cycle
//   err      out  sticky feedback mismatch (SR_CHECK_EN only)
module lab3_sr_pulse_driver #(
    parameter int DB_CNT  = 3,
    parameter int PULSE_W = 4,
    parameter int GAP_W   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic set_btn,
    input  logic clr_btn,
    input  logic q_fb,
    output logic S,
    output logic R,
    output logic busy,
    output logic exp_q,
    output logic conflict,
    output logic err
);
    localparam int MAX_A = (DB_CNT > PULSE_W) ? DB_CNT : PULSE_W;
    localparam int MAX_W = (MAX_A > GAP_W) ? MAX_A : GAP_W;
    localparam int CW    = $clog2(MAX_W + 1);

    localparam logic [CW-1:0] DB_LAST = CW'(DB_CNT);
    localparam logic [CW-1:0] PW_LAST = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] GW_LAST = CW'(GAP_W - 1);

    typedef enum logic [1:0] {IDLE, SET_P, CLR_P, GAP} state_t;

    // bit 0 = set button, bit 1 = clear button
    logic [1:0]         w_raw;
    logic [1:0]         r_sync1;
    logic [1:0]         r_sync2;
    logic [1:0]         r_lvl;
    logic [1:0]         r_press;
    logic [1:0][CW-1:0] r_dbc;

    state_t             r_state;
    state_t             w_next;
    logic [CW-1:0]      r_cnt;
    logic               w_last;
    logic               r_exp;

    assign w_raw = {clr_btn, set_btn};

    // Debounce: the counter runs while the synchronised sample disagrees with
    // the debounced level; once it has reached DB_CNT a further disagreeing
    // sample flips the level. Any agreeing sample restarts the count.
    // r_press is a one-cycle pulse on a debounced rising edge only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_lvl   <= '0;
            r_press <= '0;
            r_dbc   <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 2; i++) begin
                r_press[i] <= 1'b0;
                if (r_sync2[i] == r_lvl[i]) begin
                    r_dbc[i] <= '0;
                end else if (r_dbc[i] == DB_LAST) begin
                    r_lvl[i]   <= r_sync2[i];
                    r_press[i] <= r_sync2[i];
                    r_dbc[i]   <= '0;
                end else begin
                    r_dbc[i] <= r_dbc[i] + 1'b1;
                end
            end
        end
    end

    // Next-state logic. Presses only matter in IDLE, so anything arriving
    // during a pulse or gap is simply dropped.
    always_comb begin
        w_next   = r_state;
        w_last   = 1'b0;
        conflict = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_press[0] && !r_press[1])      w_next = SET_P;
                else if (r_press[1] && !r_press[0]) w_next = CLR_P;
                else if (r_press[0] && r_press[1])  conflict = 1'b1;
            end
            SET_P, CLR_P: begin
                if (r_cnt == PW_LAST) begin
                    w_last = 1'b1;
                    w_next = GAP;
                end
            end
            GAP: begin
                if (r_cnt == GW_LAST) begin
                    w_last = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_exp   <= 1'b0;
        end else begin
            r_state <= w_next;
            // cnt counts cycles spent in the current pulse/gap state
            if (w_last || r_state == IDLE) r_cnt <= '0;
            else                           r_cnt <= r_cnt + 1'b1;
            if (w_last && r_state == SET_P) r_exp <= 1'b1;
            if (w_last && r_state == CLR_P) r_exp <= 1'b0;
        end
    end

    // Drives decode the state register directly, so they are glitch-free and
    // a reset drops them on the same edge.
    assign S     = (r_state == SET_P);
    assign R     = (r_state == CLR_P);
    assign busy  = (r_state != IDLE);
    assign exp_q = r_exp;

`ifdef SR_CHECK_EN
    logic r_err;

    // exp_q is already final in the GAP, so the latch has had the whole gap
    // to settle before its feedback is judged.
    always_ff @(posedge clk) begin
        if (rst)                                            r_err <= 1'b0;
        else if (r_state == GAP && w_last && q_fb != r_exp) r_err <= 1'b1;
    end

    assign err = r_err;
`else
    logic w_unused_qfb;
    assign w_unused_qfb = q_fb;
    assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_lab3_sr_pulse_driver.sv
// Testbench for lab3_sr_pulse_driver. A cycle-indexed reference model holds
// the raw button history, derives debounced levels from a sliding window and
// describes each command by its start cycle and kind.
module tb_lab3_sr_pulse_driver;
    localparam int DB = 3;
    localparam int PW = 4;
    localparam int GW = 2;
    localparam int HN = 8192;

    logic clk = 1'b0;
    logic rst, set_btn, clr_btn, q_fb;
    logic S, R, busy, exp_q, conflict, err;

    lab3_sr_pulse_driver #(.DB_CNT(DB), .PULSE_W(PW), .GAP_W(GW)) dut (
        .clk(clk), .rst(rst), .set_btn(set_btn), .clr_btn(clr_btn), .q_fb(q_fb),
        .S(S), .R(R), .busy(busy), .exp_q(exp_q), .conflict(conflict), .err(err)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int miss = 0;

    // reference model state
    int n = 0;            // index of the last clock edge
    bit hs [0:HN-1];      // raw set sample at each edge
    bit hc [0:HN-1];      // raw clr sample at each edge
    bit lvl_s, lvl_c;     // debounced levels
    bit ps, pc;           // press seen in the current cycle
    bit act;              // a command has been started
    int cmd_t;            // edge at which the current command's pulse began
    bit kind;             // 1 = set command, 0 = clear command
    bit exp_m, err_m;
    bit force_q0 = 1'b0;

    // A level flips once DB+1 consecutive synchronised samples disagree with
    // it; the sample seen at edge n is the raw value from edge n-2.
    function automatic bit win_diff(input bit which, input bit lvl);
        if (n - 2 - DB < 0) return 1'b0;
        for (int k = n - 2 - DB; k <= n - 2; k++)
            if ((which ? hc[k] : hs[k]) == lvl) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [5:0] expv();
        int el;
        bit bsy;
        el  = n - cmd_t;
        bsy = act && el < PW + GW;
        return {bsy && kind && el < PW, bsy && !kind && el < PW, bsy, exp_m,
                !bsy && ps && pc, err_m};
    endfunction

    task automatic step();
        bit rs, rc, rr, qf;
        int el;
        rs = set_btn; rc = clr_btn; rr = rst; qf = q_fb;
        @(posedge clk);
        n++;
        if (rr) begin
            hs[n] = 0; hs[n-1] = 0; hc[n] = 0; hc[n-1] = 0;
            lvl_s = 0; lvl_c = 0; ps = 0; pc = 0;
            act = 0; exp_m = 0; err_m = 0;
        end else begin
            el = n - 1 - cmd_t;
            if (act && el == PW - 1) exp_m = kind;
`ifdef SR_CHECK_EN
            if (act && el == PW + GW - 1 && qf != exp_m) err_m = 1;
`endif
            if (!(act && el < PW + GW)) begin
                act = 0;
                if (ps ^ pc) begin act = 1; cmd_t = n; kind = ps; end
            end
            ps = 0; pc = 0;
            if (win_diff(1'b0, lvl_s)) begin lvl_s = ~lvl_s; ps = lvl_s; end
            if (win_diff(1'b1, lvl_c)) begin lvl_c = ~lvl_c; pc = lvl_c; end
            hs[n] = rs; hc[n] = rc;
        end
        #1;
        q_fb = force_q0 ? 1'b0 : exp_m;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_btn = 1'($urandom); clr_btn = 1'($urandom);
            step();
            vecs++;
            if ({S, R, busy, exp_q, conflict, err} !== 6'b0) begin
                miss++;
                $display("FAIL reset cyc=%0d got=%b exp=000000", n, {S, R, busy, exp_q, conflict, err});
            end
        end
        set_btn = 0; clr_btn = 0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
    endtask

    // Scenario 1 and 2: one clean press each, with absolute latency checks.
    task automatic test_press(input bit is_set);
        int t, first, cnt, other, efirst, idle_at;
        first = -1; cnt = 0; other = 0; efirst = -1; idle_at = -1;
        if (is_set) set_btn = 1'b1; else clr_btn = 1'b1;
        t = n + 1;
        for (int i = 0; i < 30; i++) begin
            if (i == 16) begin set_btn = 0; clr_btn = 0; end
            step();
            vecs++;
            if ({S, R, busy, exp_q, conflict, err} !== expv()) begin
                miss++;
                $display("FAIL press%0d cyc=%0d got=%b exp=%b", is_set, n, {S, R, busy, exp_q, conflict, err}, expv());
            end
            if ((is_set ? S : R) === 1'b1) begin cnt++; if (first < 0) first = n; end
            if ((is_set ? R : S) === 1'b1) other++;
            if (efirst < 0 && exp_q === is_set) efirst = n;
            if (first >= 0 && idle_at < 0 && busy === 1'b0) idle_at = n;
        end
        vecs++;
        if (first != t + 6 || cnt != PW || other != 0) begin
            miss++;
            $display("FAIL press%0d_pulse first=%0d cnt=%0d other=%0d need first=%0d cnt=%0d other=0", is_set, first, cnt, other, t + 6, PW);
        end
        vecs++;
        if (efirst != t + 10 || idle_at != t + 12) begin
            miss++;
            $display("FAIL press%0d_expq exp_at=%0d idle_at=%0d need %0d %0d", is_set, efirst, idle_at, t + 10, t + 12);
        end
    endtask

    // Scenario 3: bounce, short glitch, then a real press.
    task automatic test_bounce();
        int scnt, bcnt;
        scnt = 0; bcnt = 0;
        for (int i = 0; i < 46; i++) begin
            if (i < 10)      set_btn = ~i[0];
            else if (i < 20) set_btn = 1'b0;
            else if (i < 22) set_btn = 1'b1;
            else             set_btn = 1'b0;
            step();
            vecs++;
            if ({S, R, busy, exp_q, conflict, err} !== expv()) begin
                miss++;
                $display("FAIL bounce cyc=%0d got=%b exp=%b", n, {S, R, busy, exp_q, conflict, err}, expv());
            end
            if (S === 1'b1) scnt++;
            if (busy === 1'b1) bcnt++;
        end
        vecs++;
        if (scnt != 0 || bcnt != 0) begin
            miss++;
            $display("FAIL bounce_quiet S_cycles=%0d busy_cycles=%0d need 0 0", scnt, bcnt);
        end
        set_btn = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i == 12) set_btn = 1'b0;
            step();
            vecs++;
            if ({S, R, busy, exp_q, conflict, err} !== expv()) begin
                miss++;
                $display("FAIL bounce_hold cyc=%0d got=%b exp=%b", n, {S, R, busy, exp_q, conflict, err}, expv());
            end
            if (S === 1'b1) scnt++;
        end
        vecs++;
        if (scnt != PW) begin
            miss++;
            $display("FAIL bounce_pulse S_cycles=%0d need %0d", scnt, PW);
        end
    endtask

    // Scenario 4: both presses land in the same IDLE cycle.
    task automatic test_conflict();
        int ccnt, act_cnt;
        bit e0;
        ccnt = 0; act_cnt = 0; e0 = exp_q;
        set_btn = 1'b1; clr_btn = 1'b1;
        for (int i = 0; i < 28; i++) begin
            if (i == 14) begin set_btn = 0; clr_btn = 0; end
            step();
            vecs++;
            if ({S, R, busy, exp_q, conflict, err} !== expv()) begin
                miss++;
                $display("FAIL conflict cyc=%0d got=%b exp=%b", n, {S, R, busy, exp_q, conflict, err}, expv());
            end
            if (conflict === 1'b1) ccnt++;
            if (S === 1'b1 || R === 1'b1 || busy === 1'b1 || exp_q !== e0) act_cnt++;
        end
        vecs++;
        if (ccnt != 1 || act_cnt != 0) begin
            miss++;
            $display("FAIL conflict_once conflict_cycles=%0d activity=%0d need 1 0", ccnt, act_cnt);
        end
    endtask

    // Scenario 5: clr during a set pulse is dropped; reset mid-pulse.
    task automatic test_drop_and_reset();
        int rcnt, scnt, guard;
        rcnt = 0; scnt = 0;
        set_btn = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i == 3) clr_btn = 1'b1;
            if (i == 16) begin set_btn = 0; clr_btn = 0; end
            step();
            vecs++;
            if ({S, R, busy, exp_q, conflict, err} !== expv()) begin
                miss++;
                $display("FAIL drop cyc=%0d got=%b exp=%b", n, {S, R, busy, exp_q, conflict, err}, expv());
            end
            if (R === 1'b1) rcnt++;
            if (S === 1'b1) scnt++;
        end
        vecs++;
        if (rcnt != 0 || scnt != PW) begin
            miss++;
            $display("FAIL drop_clr R_cycles=%0d S_cycles=%0d need 0 %0d", rcnt, scnt, PW);
        end
        set_btn = 1'b1;
        guard = 0;
        while (S !== 1'b1 && guard < 20) begin step(); guard++; end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; set_btn = 1'b0;
        vecs++;
        if (guard >= 20 || {S, busy, exp_q} !== 3'b000 || {S, R, busy, exp_q, conflict, err} !== expv()) begin
            miss++;
            $display("FAIL mid_reset waited=%0d S=%b busy=%b exp_q=%b need 0 0 0", guard, S, busy, exp_q);
        end
        for (int i = 0; i < 12; i++) step();
    endtask

    // Scenario 6: latch feedback stuck at 0 after a set command.
    task automatic test_err();
        force_q0 = 1'b1;
        q_fb = 1'b0;
        set_btn = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i == 16) set_btn = 1'b0;
            step();
            vecs++;
            if ({S, R, busy, exp_q, conflict, err} !== expv()) begin
                miss++;
                $display("FAIL err_flag cyc=%0d got=%b exp=%b", n, {S, R, busy, exp_q, conflict, err}, expv());
            end
        end
        vecs++;
`ifdef SR_CHECK_EN
        if (err !== 1'b1) begin
            miss++;
            $display("FAIL err_sticky err=%b need 1", err);
        end
`else
        if (err !== 1'b0) begin
            miss++;
            $display("FAIL err_tied err=%b need 0", err);
        end
`endif
        force_q0 = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        vecs++;
        if (err !== 1'b0 || {S, R, busy, exp_q, conflict, err} !== expv()) begin
            miss++;
            $display("FAIL err_clear err=%b need 0", err);
        end
        for (int i = 0; i < 8; i++) step();
    endtask

    // Slowly changing random buttons with the occasional reset.
    task automatic test_random();
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 7) == 0) set_btn = ~set_btn;
            if ($urandom_range(0, 7) == 0) clr_btn = ~clr_btn;
            rst = ($urandom_range(0, 299) == 0);
            step();
            vecs++;
            if ({S, R, busy, exp_q, conflict, err} !== expv()) begin
                miss++;
                $display("FAIL random cyc=%0d got=%b exp=%b", n, {S, R, busy, exp_q, conflict, err}, expv());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; set_btn = 1'b0; clr_btn = 1'b0; q_fb = 1'b0;
        cmd_t = 0; kind = 0;
        test_reset();
        test_press(1'b1);
        test_press(1'b0);
        test_bounce();
        test_conflict();
        test_drop_and_reset();
        test_err();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
